riscv_wb_arbiter: RTL and testbench

RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

---
 rtl/riscv_wb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_riscv_wb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_arbiter.sv
//============================================================================
// Module  : riscv_wb_arbiter
// Brief   : Register-file write-port arbiter between the WB stage and a FIFO
//           of long-latency unit results, with starvation-triggered drain.
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module riscv_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_pipe_wr_en,
  input  logic [4:0]                 i_pipe_rd,
  input  logic [`XLEN-1:0]           i_pipe_rd_data,
  output logic                       o_pipe_stall,
  input  logic                       i_lu_valid,
  output logic                       o_lu_ready,
  input  logic [4:0]                 i_lu_rd,
  input  logic [`XLEN-1:0]           i_lu_rd_data,
  output logic                       o_rf_wr_en,
  output logic [4:0]                 o_rf_rd,
  output logic [`XLEN-1:0]           o_rf_rd_data,
  output logic [31:0]                o_pend_mask,
  output logic [$clog2(DEPTH+1)-1:0] o_pend_cnt
);

  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_AGE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
  localparam logic [c_AGE_W-1:0] c_AGE_MAX  = c_AGE_W'(STARVE_LIMIT);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);

  localparam logic [0:0] c_ST_NORMAL = 1'b0;
  localparam logic [0:0] c_ST_DRAIN  = 1'b1;

  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_AGE_W-1:0] r_age;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [DEPTH-1:0]   r_valid;
  logic [4:0]         r_buf_rd   [DEPTH];
  logic [`XLEN-1:0]   r_buf_data [DEPTH];

  logic [0:0]         w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_AGE_W-1:0] w_age_upd;
  logic               w_head_vld;
  logic               w_lu_ready;
  logic               w_pipe_eff;
  logic               w_sel_pipe;
  logic               w_deq;
  logic               w_enq;
  logic               w_rf_en;
  logic [31:0]        w_mask;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_head_vld = (r_cnt != '0);
  assign w_lu_ready = (r_cnt < c_CNT_FULL);
  assign w_pipe_eff = i_pipe_wr_en & (i_pipe_rd != 5'd0);
  // x0 results are acknowledged but never stored
  assign w_enq      = i_lu_valid & w_lu_ready & (i_lu_rd != 5'd0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_enq, w_deq})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_comb begin
    w_age_upd = '0;
    if (r_state == c_ST_NORMAL && w_head_vld && !w_deq)
      w_age_upd = r_age + 1'b1;
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= c_ST_NORMAL;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_NORMAL:
        if (w_cnt_nxt == c_CNT_FULL || w_age_upd == c_AGE_MAX)
          w_state_nxt = c_ST_DRAIN;
      c_ST_DRAIN:
        if (w_cnt_nxt == '0)
          w_state_nxt = c_ST_NORMAL;
      default:
        w_state_nxt = c_ST_NORMAL;
    endcase
  end

  // FSM: outputs / port selection
  always_comb begin
    w_sel_pipe   = 1'b0;
    w_deq        = 1'b0;
    o_pipe_stall = 1'b0;
    case (r_state)
      c_ST_NORMAL: begin
        w_sel_pipe = w_pipe_eff;
        w_deq      = w_head_vld & ~w_pipe_eff;
      end
      c_ST_DRAIN: begin
        w_deq        = w_head_vld;
        o_pipe_stall = ~i_rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_age   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_valid <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_age <= (w_state_nxt == c_ST_DRAIN) ? '0 : w_age_upd;
      if (w_deq) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= ptr_inc(r_rptr);
      end
      if (w_enq) begin
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= ptr_inc(r_wptr);
      end
    end
  end

  // Payload storage needs no reset: r_valid/r_cnt qualify every use
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_buf_rd[r_wptr]   <= i_lu_rd;
      r_buf_data[r_wptr] <= i_lu_rd_data;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_valid[i]) w_mask[r_buf_rd[i]] = 1'b1;
  end

  assign w_rf_en    = (w_sel_pipe | w_deq) & ~i_rst;
  assign o_rf_wr_en = w_rf_en;

  always_comb begin
    o_rf_rd      = '0;
    o_rf_rd_data = '0;
    if (w_rf_en) begin
      if (w_sel_pipe) begin
        o_rf_rd      = i_pipe_rd;
        o_rf_rd_data = i_pipe_rd_data;
      end else begin
        o_rf_rd      = r_buf_rd[r_rptr];
        o_rf_rd_data = r_buf_data[r_rptr];
      end
    end
  end

  assign o_lu_ready  = w_lu_ready;
  assign o_pend_cnt  = r_cnt;
  assign o_pend_mask = w_mask;

endmodule

`default_nettype wire

// File: tb/tb_riscv_wb_arbiter.sv
//============================================================================
// Module  : tb_riscv_wb_arbiter
// Brief   : Directed + random bench for riscv_wb_arbiter against a queue model.
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

module tb_riscv_wb_arbiter;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int XLEN         = 32;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_pipe_wr_en;
  logic [4:0]      i_pipe_rd;
  logic [XLEN-1:0] i_pipe_rd_data;
  logic            o_pipe_stall;
  logic            i_lu_valid;
  logic            o_lu_ready;
  logic [4:0]      i_lu_rd;
  logic [XLEN-1:0] i_lu_rd_data;
  logic            o_rf_wr_en;
  logic [4:0]      o_rf_rd;
  logic [XLEN-1:0] o_rf_rd_data;
  logic [31:0]     o_pend_mask;
  logic [1:0]      o_pend_cnt;

  riscv_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pipe_wr_en(i_pipe_wr_en), .i_pipe_rd(i_pipe_rd), .i_pipe_rd_data(i_pipe_rd_data),
    .o_pipe_stall(o_pipe_stall),
    .i_lu_valid(i_lu_valid), .o_lu_ready(o_lu_ready), .i_lu_rd(i_lu_rd), .i_lu_rd_data(i_lu_rd_data),
    .o_rf_wr_en(o_rf_wr_en), .o_rf_rd(o_rf_rd), .o_rf_rd_data(o_rf_rd_data),
    .o_pend_mask(o_pend_mask), .o_pend_cnt(o_pend_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ordered list of buffered results plus drain/age bookkeeping
  typedef struct packed { logic [4:0] rd; logic [XLEN-1:0] data; } ent_t;
  ent_t m_q[$];
  bit   m_drain = 1'b0;
  int   m_age   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's outputs against the model, then clock and advance the model.
  task automatic cycle();
    logic [4:0]      e_rd;
    logic [XLEN-1:0] e_data;
    logic [31:0]     e_mask;
    bit              e_en, pop, acc, had_head;
    #1;
    e_en = 1'b0; e_rd = '0; e_data = '0; pop = 1'b0; e_mask = '0;
    if (i_rst) begin
      chk("rst_wr_en", 64'(o_rf_wr_en), 64'd0);
      chk("rst_stall", 64'(o_pipe_stall), 64'd0);
    end else begin
      if (!m_drain && i_pipe_wr_en && i_pipe_rd != 5'd0) begin
        e_en = 1'b1; e_rd = i_pipe_rd; e_data = i_pipe_rd_data;
      end else if (m_q.size() > 0) begin
        e_en = 1'b1; e_rd = m_q[0].rd; e_data = m_q[0].data; pop = 1'b1;
      end
      foreach (m_q[k]) e_mask[m_q[k].rd] = 1'b1;
      chk("rf_wr_en", 64'(o_rf_wr_en), 64'(e_en));
      chk("rf_rd",    64'(o_rf_rd),    64'(e_rd));
      chk("rf_data",  64'(o_rf_rd_data), 64'(e_data));
      chk("stall",    64'(o_pipe_stall), 64'(m_drain));
      chk("lu_ready", 64'(o_lu_ready), 64'(m_q.size() < DEPTH));
      chk("pend_cnt", 64'(o_pend_cnt), 64'(m_q.size()));
      chk("pend_mask", 64'(o_pend_mask), 64'(e_mask));
    end
    @(posedge i_clk);
    if (i_rst) begin
      m_q.delete();
      m_drain = 1'b0;
      m_age   = 0;
    end else begin
      had_head = (m_q.size() > 0);
      acc      = i_lu_valid && (m_q.size() < DEPTH) && (i_lu_rd != 5'd0);
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back({i_lu_rd, i_lu_rd_data});
      if (!m_drain) begin
        m_age = (had_head && !pop) ? m_age + 1 : 0;
        if (m_q.size() == DEPTH || m_age == STARVE_LIMIT) begin
          m_drain = 1'b1;
          m_age   = 0;
        end
      end else begin
        m_age = 0;
        if (m_q.size() == 0) m_drain = 1'b0;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic idle();
    i_pipe_wr_en = 1'b0; i_pipe_rd = '0; i_pipe_rd_data = '0;
    i_lu_valid   = 1'b0; i_lu_rd   = '0; i_lu_rd_data   = '0;
  endtask

  int stalls;
  int x7_at;

  initial begin
    idle();
    i_rst = 1'b1;
    @(negedge i_clk);
    cycle();
    i_rst = 1'b0;
    #1;
    chk("reset_cnt",   64'(o_pend_cnt), 64'd0);
    chk("reset_mask",  64'(o_pend_mask), 64'd0);
    chk("reset_ready", 64'(o_lu_ready), 64'd1);
    cycle();

    // Single result, idle pipe: written the following cycle
    i_lu_valid = 1'b1; i_lu_rd = 5'd5; i_lu_rd_data = 32'hA5;
    cycle();
    idle();
    #1;
    chk("single_en",   64'(o_rf_wr_en), 64'd1);
    chk("single_rd",   64'(o_rf_rd), 64'd5);
    chk("single_data", 64'(o_rf_rd_data), 64'hA5);
    cycle();
    chk("single_cnt0", 64'(o_pend_cnt), 64'd0);
    cycle();

    // Starvation: busy pipe blocks x7 until the age limit forces a drain
    i_pipe_wr_en = 1'b1; i_pipe_rd = 5'd1; i_pipe_rd_data = 32'h1111;
    i_lu_valid = 1'b1; i_lu_rd = 5'd7; i_lu_rd_data = 32'h77;
    cycle();
    i_lu_valid = 1'b0;
    stalls = 0; x7_at = -1;
    for (int i = 0; i < 8; i++) begin
      #1;
      stalls += int'(o_pipe_stall);
      if (o_rf_wr_en && o_rf_rd == 5'd7) x7_at = i;
      cycle();
    end
    chk("starve_stalls", 64'(stalls), 64'd1);
    chk("starve_x7_cycle", 64'(x7_at), 64'd4);

    // Full buffer: x3,x4 drained in order
    i_lu_valid = 1'b1; i_lu_rd = 5'd3; i_lu_rd_data = 32'h33;
    cycle();
    i_lu_rd = 5'd4; i_lu_rd_data = 32'h44;
    cycle();
    i_lu_valid = 1'b0;
    #1;
    chk("full_mask18", 64'(o_pend_mask), 64'h18);
    chk("full_ready0", 64'(o_lu_ready), 64'd0);
    chk("full_rd3",    64'(o_rf_rd), 64'd3);
    cycle();
    chk("full_mask10", 64'(o_pend_mask), 64'h10);
    chk("full_rd4",    64'(o_rf_rd), 64'd4);
    cycle();
    chk("full_mask0",  64'(o_pend_mask), 64'h0);
    chk("full_stall0", 64'(o_pipe_stall), 64'd0);
    cycle();

    // x0 on both sides: nothing happens
    i_pipe_wr_en = 1'b1; i_pipe_rd = 5'd0; i_pipe_rd_data = 32'hDEAD;
    i_lu_valid = 1'b1; i_lu_rd = 5'd0; i_lu_rd_data = 32'hBEEF;
    #1;
    chk("x0_wr_en", 64'(o_rf_wr_en), 64'd0);
    cycle();
    idle();
    chk("x0_cnt", 64'(o_pend_cnt), 64'd0);
    chk("x0_stall", 64'(o_pipe_stall), 64'd0);
    cycle();

    // Reset in DRAIN with two entries buffered
    i_pipe_wr_en = 1'b1; i_pipe_rd = 5'd1; i_pipe_rd_data = 32'h1;
    i_lu_valid = 1'b1; i_lu_rd = 5'd9; i_lu_rd_data = 32'h99;
    cycle();
    i_lu_rd = 5'd10; i_lu_rd_data = 32'hAA;
    cycle();
    idle();
    chk("pre_rst_cnt", 64'(o_pend_cnt), 64'd2);
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    #1;
    chk("post_rst_cnt",   64'(o_pend_cnt), 64'd0);
    chk("post_rst_mask",  64'(o_pend_mask), 64'd0);
    chk("post_rst_stall", 64'(o_pipe_stall), 64'd0);
    chk("post_rst_wr",    64'(o_rf_wr_en), 64'd0);
    cycle();

    // Streaming at cnt=1 across pointer wrap
    i_lu_valid = 1'b1; i_lu_rd = 5'd1; i_lu_rd_data = $urandom;
    cycle();
    for (int i = 1; i <= 10; i++) begin
      i_lu_rd = 5'(i + 1); i_lu_rd_data = $urandom;
      #1;
      chk("stream_cnt1", 64'(o_pend_cnt), 64'd1);
      chk("stream_order", 64'(o_rf_rd), 64'(i));
      cycle();
    end
    idle();
    cycle();
    cycle();

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      i_rst          = ($urandom_range(0, 49) == 0);
      i_pipe_wr_en   = $urandom_range(0, 1);
      i_pipe_rd      = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      i_pipe_rd_data = $urandom;
      i_lu_valid     = $urandom_range(0, 1);
      i_lu_rd        = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
      i_lu_rd_data   = $urandom;
      cycle();
    end
    i_rst = 1'b0;
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
